// File: rtl/falling_action_scheduler_pkg.sv
// Shared types and constants for the falling-piece action scheduler.
package falling_action_scheduler_pkg;

  localparam int unsigned TEST_POSITIONS  = 5;
  localparam int unsigned LOCK_DELAY      = 30;
  localparam int unsigned MAX_LOCK_RESETS = 15;

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_ROT_R,
    ACT_ROT_L,
    ACT_MOV_R,
    ACT_MOV_L,
    ACT_SOFT_DROP,
    ACT_HARD_DROP
  } action_t;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    READY,
    HARD_LOCK
  } sched_state_t;

  localparam int unsigned PEND_ROT_R = 0;
  localparam int unsigned PEND_ROT_L = 1;
  localparam int unsigned PEND_MOV_R = 2;
  localparam int unsigned PEND_MOV_L = 3;
  localparam int unsigned PEND_DOWN  = 4;
  localparam int unsigned PEND_HARD  = 5;
  localparam int unsigned PEND_W     = 6;

  function automatic logic [PEND_W-1:0] pend_mask(input action_t act);
    logic [PEND_W-1:0] m;
    m = '0;
    case (act)
      ACT_ROT_R:     m[PEND_ROT_R] = 1'b1;
      ACT_ROT_L:     m[PEND_ROT_L] = 1'b1;
      ACT_MOV_R:     m[PEND_MOV_R] = 1'b1;
      ACT_MOV_L:     m[PEND_MOV_L] = 1'b1;
      ACT_SOFT_DROP: m[PEND_DOWN]  = 1'b1;
      ACT_HARD_DROP: m[PEND_HARD]  = 1'b1;
      default:       m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/falling_action_scheduler_counter.sv
// Loadable down-counter that stops at zero.
module falling_action_scheduler_counter #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/falling_action_scheduler.sv
// Arbitrates latched piece requests against checker results, one commit per
// settle window, and runs the lock-delay timer.
module falling_action_scheduler #(
  parameter int unsigned TEST_POSITIONS  = falling_action_scheduler_pkg::TEST_POSITIONS,
  parameter int unsigned SETTLE_CYCLES   = TEST_POSITIONS + 1,
  parameter int unsigned LOCK_DELAY      = falling_action_scheduler_pkg::LOCK_DELAY,
  parameter int unsigned MAX_LOCK_RESETS = falling_action_scheduler_pkg::MAX_LOCK_RESETS
) (
  input  logic       clk,
  input  logic       rst_l,
  input  logic       spawn,
  input  logic       req_rotate_R,
  input  logic       req_rotate_L,
  input  logic       req_move_R,
  input  logic       req_move_L,
  input  logic       req_soft_drop,
  input  logic       req_hard_drop,
  input  logic       gravity_tick,
  input  logic       rotate_R_valid,
  input  logic       rotate_L_valid,
  input  logic       move_R_valid,
  input  logic       move_L_valid,
  input  logic       soft_drop_valid,
  output logic       commit_valid,
  output logic [2:0] commit_action,
  output logic       lock_piece,
  output logic       busy
);
  import falling_action_scheduler_pkg::*;

  localparam int unsigned SW = $clog2(SETTLE_CYCLES);
  localparam int unsigned LW = $clog2(LOCK_DELAY);
  localparam int unsigned RW = $clog2(MAX_LOCK_RESETS + 1);

  sched_state_t      state;
  logic [PEND_W-1:0] pend, pend_set, sel_mask;
  logic [LW-1:0]     lock_cnt;
  logic [RW-1:0]     reset_cnt;
  logic [SW-1:0]     settle_cnt;
  logic              grounded;
  action_t           sel_act;
  logic              sel_ok, lock_run, lock_expire, enter_settle;

  always_comb begin
    pend_set = '0;
    if ((state == SETTLE) || (state == READY)) begin
      pend_set = {req_hard_drop, gravity_tick | req_soft_drop, req_move_L,
                  req_move_R, req_rotate_L, req_rotate_R};
    end
    lock_run    = grounded || !soft_drop_valid;
    lock_expire = (state == READY) && lock_run && (lock_cnt == LW'(LOCK_DELAY - 1));

    sel_act = ACT_NONE;
    sel_ok  = 1'b0;
    if (pend[PEND_HARD]) begin
      sel_act = ACT_HARD_DROP; sel_ok = 1'b1;
    end else if (pend[PEND_ROT_R]) begin
      sel_act = ACT_ROT_R;     sel_ok = rotate_R_valid;
    end else if (pend[PEND_ROT_L]) begin
      sel_act = ACT_ROT_L;     sel_ok = rotate_L_valid;
    end else if (pend[PEND_MOV_R]) begin
      sel_act = ACT_MOV_R;     sel_ok = move_R_valid;
    end else if (pend[PEND_MOV_L]) begin
      sel_act = ACT_MOV_L;     sel_ok = move_L_valid;
    end else if (pend[PEND_DOWN]) begin
      sel_act = ACT_SOFT_DROP; sel_ok = soft_drop_valid;
    end
    sel_mask = pend_mask(sel_act);

    enter_settle = spawn || ((state == READY) && !lock_expire && sel_ok &&
                             (sel_act != ACT_HARD_DROP));
  end

  falling_action_scheduler_counter #(
    .WIDTH(SW)
  ) u_settle_cnt (
    .clk      (clk),
    .rst_l    (rst_l),
    .load     (enter_settle),
    .en       (state == SETTLE),
    .load_val (SW'(SETTLE_CYCLES - 1)),
    .count    (settle_cnt)
  );

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state         <= IDLE;
      commit_valid  <= 1'b0;
      commit_action <= ACT_NONE;
      lock_piece    <= 1'b0;
      busy          <= 1'b0;
      pend          <= '0;
      lock_cnt      <= '0;
      reset_cnt     <= '0;
      grounded      <= 1'b0;
    end else begin
      commit_valid <= 1'b0;
      lock_piece   <= 1'b0;
      pend         <= pend | pend_set;
      if (spawn) begin
        state     <= SETTLE;
        busy      <= 1'b1;
        pend      <= '0;
        lock_cnt  <= '0;
        reset_cnt <= '0;
        grounded  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: busy <= 1'b0;
          SETTLE: begin
            if (settle_cnt == '0) begin
              state <= READY;
              busy  <= 1'b0;
            end
          end
          READY: begin
            // Clears apply before this cycle's new requests, so a same-cycle set survives.
            if (lock_expire) begin
              lock_piece <= 1'b1;
              pend       <= pend_set;
              state      <= IDLE;
            end else begin
              if (lock_run) lock_cnt <= lock_cnt + LW'(1);
              pend <= (pend & ~sel_mask) | pend_set;
              if (sel_act == ACT_HARD_DROP) begin
                commit_valid  <= 1'b1;
                commit_action <= ACT_HARD_DROP;
                pend          <= pend_set;
                state         <= HARD_LOCK;
              end else if (sel_ok) begin
                commit_valid  <= 1'b1;
                commit_action <= sel_act;
                state         <= SETTLE;
                busy          <= 1'b1;
                if (sel_act == ACT_SOFT_DROP) begin
                  lock_cnt <= '0;
                  grounded <= 1'b0;
                end else if (reset_cnt < RW'(MAX_LOCK_RESETS)) begin
                  lock_cnt  <= '0;
                  reset_cnt <= reset_cnt + RW'(1);
                end
              end else if (sel_act == ACT_SOFT_DROP) begin
                grounded <= 1'b1;
              end
            end
          end
          HARD_LOCK: begin
            lock_piece <= 1'b1;
            state      <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_falling_action_scheduler.sv
// Bench for falling_action_scheduler: directed scenarios plus random traffic
// compared every cycle against a rule-level model.
module tb_falling_action_scheduler;
  import falling_action_scheduler_pkg::*;

  localparam int SETTLE_N = 6;
  localparam int LOCK_N   = 30;
  localparam int MAXR     = 15;

  logic clk = 1'b0, rst_l = 1'b0;
  logic spawn = 1'b0, req_rotate_R = 1'b0, req_rotate_L = 1'b0, req_move_R = 1'b0;
  logic req_move_L = 1'b0, req_soft_drop = 1'b0, req_hard_drop = 1'b0, gravity_tick = 1'b0;
  logic rotate_R_valid = 1'b1, rotate_L_valid = 1'b1, move_R_valid = 1'b1;
  logic move_L_valid = 1'b1, soft_drop_valid = 1'b1;
  logic commit_valid, lock_piece, busy;
  logic [2:0] commit_action;

  int n_checks = 0, n_pass = 0;

  falling_action_scheduler dut (
    .clk(clk), .rst_l(rst_l), .spawn(spawn),
    .req_rotate_R(req_rotate_R), .req_rotate_L(req_rotate_L),
    .req_move_R(req_move_R), .req_move_L(req_move_L),
    .req_soft_drop(req_soft_drop), .req_hard_drop(req_hard_drop),
    .gravity_tick(gravity_tick),
    .rotate_R_valid(rotate_R_valid), .rotate_L_valid(rotate_L_valid),
    .move_R_valid(move_R_valid), .move_L_valid(move_L_valid),
    .soft_drop_valid(soft_drop_valid),
    .commit_valid(commit_valid), .commit_action(commit_action),
    .lock_piece(lock_piece), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: priority index 0=hard 1=rotR 2=rotL 3=movR 4=movL 5=down
  typedef enum {M_IDLE, M_SETTLE, M_READY, M_HARD} mph_t;
  mph_t       m_ph = M_IDLE;
  bit         m_pend[6];
  int         m_left = 0, m_lock = 0, m_resets = 0;
  bit         m_gnd = 1'b0;
  bit         e_cv = 1'b0, e_lp = 1'b0, e_busy = 1'b0;
  logic [2:0] e_act = ACT_NONE;

  function automatic logic [2:0] act_of(input int p);
    case (p)
      0: return ACT_HARD_DROP;
      1: return ACT_ROT_R;
      2: return ACT_ROT_L;
      3: return ACT_MOV_R;
      4: return ACT_MOV_L;
      default: return ACT_SOFT_DROP;
    endcase
  endfunction

  task automatic model_step();
    bit r[6];
    bit v[6];
    bit accept, counting;
    int p;
    r[0] = req_hard_drop; r[1] = req_rotate_R; r[2] = req_rotate_L;
    r[3] = req_move_R;    r[4] = req_move_L;   r[5] = req_soft_drop | gravity_tick;
    v[0] = 1'b1;          v[1] = rotate_R_valid; v[2] = rotate_L_valid;
    v[3] = move_R_valid;  v[4] = move_L_valid;   v[5] = soft_drop_valid;
    accept   = (m_ph == M_SETTLE) || (m_ph == M_READY);
    counting = m_gnd || !soft_drop_valid;
    e_cv = 1'b0;
    e_lp = 1'b0;
    if (spawn) begin
      m_ph = M_SETTLE; m_left = SETTLE_N; m_lock = 0; m_resets = 0; m_gnd = 1'b0;
      foreach (m_pend[i]) m_pend[i] = 1'b0;
    end else begin
      case (m_ph)
        M_SETTLE: begin
          m_left--;
          if (m_left == 0) m_ph = M_READY;
        end
        M_READY: begin
          if (counting && m_lock == LOCK_N - 1) begin
            e_lp = 1'b1;
            m_ph = M_IDLE;
            foreach (m_pend[i]) m_pend[i] = 1'b0;
          end else begin
            p = -1;
            if (counting) m_lock++;
            for (int i = 0; i < 6; i++) if (m_pend[i] && p < 0) p = i;
            if (p == 0) begin
              e_cv = 1'b1; e_act = ACT_HARD_DROP; m_ph = M_HARD;
              foreach (m_pend[i]) m_pend[i] = 1'b0;
            end else if (p > 0) begin
              m_pend[p] = 1'b0;
              if (v[p]) begin
                e_cv = 1'b1; e_act = act_of(p); m_ph = M_SETTLE; m_left = SETTLE_N;
                if (p == 5) begin
                  m_lock = 0; m_gnd = 1'b0;
                end else if (m_resets < MAXR) begin
                  m_lock = 0; m_resets++;
                end
              end else if (p == 5) begin
                m_gnd = 1'b1;
              end
            end
          end
        end
        M_HARD: begin
          e_lp = 1'b1;
          m_ph = M_IDLE;
        end
        default: ;
      endcase
      if (accept) foreach (m_pend[i]) m_pend[i] = m_pend[i] | r[i];
    end
    e_busy = (m_ph == M_SETTLE);
  endtask

  initial forever begin
    @(posedge clk);
    if (rst_l) model_step();
  end

  initial forever begin
    @(negedge clk);
    if (rst_l) begin
      check("commit_valid", int'(commit_valid), int'(e_cv));
      check("commit_action", int'(commit_action), int'(e_act));
      check("lock_piece", int'(lock_piece), int'(e_lp));
      check("busy", int'(busy), int'(e_busy));
      check("commit_lock_exclusive", int'(commit_valid & lock_piece), 0);
    end
  end

  // Event log sampled just after each rising edge
  int cyc = 0, ncommit = 0, nlock = 0, busy_run = 0, last_busy_run = 0;
  int busy_fall_cyc = -1, lock_cyc = -1;
  int ccyc[$];
  logic [2:0] last_act = ACT_NONE;

  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    if (busy) busy_run++;
    else if (busy_run > 0) begin
      last_busy_run = busy_run; busy_run = 0; busy_fall_cyc = cyc;
    end
    if (commit_valid) begin
      ncommit++; ccyc.push_back(cyc); last_act = commit_action;
    end
    if (lock_piece) begin
      nlock++; lock_cyc = cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_pulses();
    spawn = 1'b0; req_rotate_R = 1'b0; req_rotate_L = 1'b0; req_move_R = 1'b0;
    req_move_L = 1'b0; req_soft_drop = 1'b0; req_hard_drop = 1'b0; gravity_tick = 1'b0;
  endtask

  task automatic wait_n(input string name, input int kind, input int target, input int budget);
    int i = 0;
    while ((((kind == 0) ? ncommit : nlock) < target) && (i < budget)) begin
      tick(1);
      i++;
    end
    check(name, int'((((kind == 0) ? ncommit : nlock) >= target)), 1);
  endtask

  task automatic wait_ready(input string name);
    int i = 0;
    do begin
      tick(1);
      i++;
    end while (busy && i < 30);
    check(name, int'(busy), 0);
  endtask

  int c0, l0, s0, base;

  initial begin
    tick(2);
    check("rst_commit_valid", int'(commit_valid), 0);
    check("rst_commit_action", int'(commit_action), int'(ACT_NONE));
    check("rst_lock_piece", int'(lock_piece), 0);
    check("rst_busy", int'(busy), 0);
    rst_l = 1'b1;
    tick(2);

    // Spawn, then a valid move-left one cycle later
    spawn = 1'b1; tick(1); clear_pulses();
    req_move_L = 1'b1; tick(1); clear_pulses();
    wait_n("A_commit_seen", 0, 1, 20);
    check("A_settle_len", last_busy_run, SETTLE_N);
    check("A_action", int'(last_act), int'(ACT_MOV_L));
    check("A_resettle", int'(busy), 1);

    // Rotate and move together: rotate first, move one settle window later
    req_rotate_R = 1'b1; req_move_R = 1'b1; tick(1); clear_pulses();
    wait_n("B_first_seen", 0, 2, 20);
    check("B_first_action", int'(last_act), int'(ACT_ROT_R));
    wait_n("B_second_seen", 0, 3, 20);
    check("B_second_action", int'(last_act), int'(ACT_MOV_R));
    check("B_gap", ccyc[2] - ccyc[1], SETTLE_N + 1);

    // Invalid rotate is consumed without a commit
    wait_ready("C_ready");
    rotate_L_valid = 1'b0; req_rotate_L = 1'b1; tick(1); clear_pulses();
    c0 = ncommit;
    tick(8);
    check("C_no_commit", ncommit, c0);
    check("C_stays_ready", int'(busy), 0);
    rotate_L_valid = 1'b1;
    tick(3);
    check("C_bit_cleared", ncommit, c0);

    // Grounded piece locks after LOCK_N counting cycles; then requests are dropped
    soft_drop_valid = 1'b0; gravity_tick = 1'b1; s0 = cyc; tick(1); clear_pulses();
    wait_n("D_lock_seen", 1, 1, 40);
    check("D_lock_delay", lock_cyc - s0, LOCK_N);
    soft_drop_valid = 1'b1;
    req_move_R = 1'b1; c0 = ncommit; tick(1); clear_pulses();
    tick(10);
    check("D_idle_ignores", ncommit, c0);
    check("D_idle_busy", int'(busy), 0);

    // Sixteen valid moves on a grounded piece: only fifteen restart the timer
    spawn = 1'b1; tick(1); clear_pulses();
    wait_ready("E_ready");
    soft_drop_valid = 1'b0; gravity_tick = 1'b1; tick(1); clear_pulses();
    tick(4);
    base = ncommit;
    for (int k = 0; k < 16; k++) begin
      req_move_R = 1'b1; tick(1); clear_pulses();
      tick(9);
    end
    wait_n("E_lock_seen", 1, 2, 80);
    check("E_commits", ncommit - base, 16);
    check("E_lock_after_15th", lock_cyc - ccyc[base + 14], SETTLE_N + LOCK_N + SETTLE_N);
    soft_drop_valid = 1'b1;

    // Hard drop beats a same-cycle rotate; lock follows on the next cycle
    spawn = 1'b1; tick(1); clear_pulses();
    tick(2);
    req_hard_drop = 1'b1; req_rotate_R = 1'b1; c0 = ncommit; l0 = nlock;
    tick(1); clear_pulses();
    wait_n("F_commit_seen", 0, c0 + 1, 20);
    check("F_action", int'(last_act), int'(ACT_HARD_DROP));
    wait_n("F_lock_seen", 1, l0 + 1, 5);
    check("F_lock_next", lock_cyc - ccyc[c0], 1);
    tick(10);
    check("F_no_rotate", ncommit, c0 + 1);

    // Respawn mid-settle restarts the window and drops pending requests
    spawn = 1'b1; tick(1); clear_pulses();
    tick(2);
    req_rotate_R = 1'b1; tick(1); clear_pulses();
    tick(1);
    spawn = 1'b1; s0 = cyc; tick(1); clear_pulses();
    c0 = ncommit;
    wait_ready("G_ready");
    check("G_settle_restart", busy_fall_cyc - (s0 + 1), SETTLE_N);
    tick(10);
    check("G_pending_dropped", ncommit, c0);

    // Random traffic; odd segments mostly hold soft_drop_valid low to exercise locks
    for (int i = 0; i < 4000; i++) begin
      spawn          = ($urandom_range(0, 79) == 0);
      req_rotate_R   = ($urandom_range(0, 9) == 0);
      req_rotate_L   = ($urandom_range(0, 9) == 0);
      req_move_R     = ($urandom_range(0, 9) == 0);
      req_move_L     = ($urandom_range(0, 9) == 0);
      req_soft_drop  = ($urandom_range(0, 19) == 0);
      req_hard_drop  = ($urandom_range(0, 59) == 0);
      gravity_tick   = ($urandom_range(0, 14) == 0);
      rotate_R_valid = ($urandom_range(0, 3) != 0);
      rotate_L_valid = ($urandom_range(0, 3) != 0);
      move_R_valid   = ($urandom_range(0, 3) != 0);
      move_L_valid   = ($urandom_range(0, 3) != 0);
      if (((i / 500) % 2) == 1) soft_drop_valid = ($urandom_range(0, 9) == 0);
      else                      soft_drop_valid = ($urandom_range(0, 3) != 0);
      tick(1);
    end
    clear_pulses();
    tick(5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
